// File: rtl/aes_sub_bytes_serial_if.sv
// rtl/aes_sub_bytes_serial_if.sv - block handshake and data bus for the serial AES SubBytes unit
interface aes_sub_bytes_serial_if;
  logic         v_i;
  logic         ready_o;
  logic [127:0] data_i;
  logic         v_o;
  logic         ready_i;
  logic [127:0] data_o;

  // Unit side: consumes input blocks, produces substituted blocks
  modport slave (
    input  v_i,
    input  data_i,
    input  ready_i,
    output ready_o,
    output v_o,
    output data_o
  );

  // Producer/consumer side
  modport master (
    output v_i,
    output data_i,
    output ready_i,
    input  ready_o,
    input  v_o,
    input  data_o
  );
endinterface

// File: rtl/aes_sub_bytes_serial.sv
// rtl/aes_sub_bytes_serial.sv - byte-serial AES SubBytes over a 128-bit state, one S-box lookup per cycle
module rom_sbox (
  input  logic [7:0] rom_addr,
  output logic [7:0] data_o
);
  // Forward AES S-box, entry 0 leftmost
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SBOX[rom_addr];
endmodule

module aes_sub_bytes_serial (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  aes_sub_bytes_serial_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   cnt;
  logic [127:0] st;
  logic [6:0]   byte_msb;
  logic [7:0]   cur_byte;
  logic [7:0]   sub_byte;

  // Byte k sits at st[127-8k -: 8], so byte 0 is the most significant
  assign byte_msb = 7'd127 - {cnt, 3'b000};
  assign cur_byte = st[byte_msb -: 8];

  rom_sbox u_sbox (
    .rom_addr (cur_byte),
    .data_o   (sub_byte)
  );

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: accept in IDLE, 16 byte steps in BUSY, hold result in DONE until taken
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.v_i) state_nxt = BUSY;
      BUSY: if (cnt == 4'd15) state_nxt = DONE;
      DONE: if (bus.ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load the block, then substitute one byte in place per cycle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      st  <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.v_i) begin
            st  <= bus.data_i;
            cnt <= '0;
          end
        end
        BUSY: begin
          st[byte_msb -: 8] <= sub_byte;
          cnt               <= cnt + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs are pure state decodes; result comes straight from the state register
  assign bus.ready_o = (state == IDLE);
  assign bus.v_o     = (state == DONE);
  assign bus.data_o  = st;
endmodule

// File: tb/tb_aes_sub_bytes_serial.sv
// tb/tb_aes_sub_bytes_serial.sv - directed self-checking bench for aes_sub_bytes_serial
module tb_aes_sub_bytes_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  aes_sub_bytes_serial_if bus ();

  aes_sub_bytes_serial dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] ZERO_IN   = 128'h0;
  localparam logic [127:0] ZERO_OUT  = {16{8'h63}};
  localparam logic [127:0] ORD_IN    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ORD_OUT   = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] MIX_IN    = 128'h53ff0053ff0053ff0053ff0053ff0053;
  localparam logic [127:0] MIX_OUT   = 128'hed1663ed1663ed1663ed1663ed1663ed;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; presents one block for one cycle and
  // returns the cycle number (accept cycle = 0) in which v_o is first seen high.
  // pulse_at > 1 drives a stray all-ones block during that BUSY cycle.
  task automatic run_block(input logic [127:0] din, input int pulse_at, output int lat);
    bus.v_i    = 1'b1;
    bus.data_i = din;
    @(negedge clk);
    bus.v_i    = 1'b0;
    bus.data_i = '0;
    lat = 1;
    chk("busy_ready_low", 128'(bus.ready_o), 128'd0);
    while (!bus.v_o && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == pulse_at) begin
        bus.v_i    = 1'b1;
        bus.data_i = '1;
      end else if (lat == pulse_at + 1) begin
        bus.v_i    = 1'b0;
        bus.data_i = '0;
      end
    end
  endtask

  initial begin
    int lat;
    int seen;
    logic [127:0] held;

    bus.v_i     = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;

    // Reset state
    #2;
    chk("rst_ready", 128'(bus.ready_o), 128'd1);
    chk("rst_v", 128'(bus.v_o), 128'd0);
    chk("rst_data", bus.data_o, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero block with ready_i held high
    bus.ready_i = 1'b1;
    run_block(ZERO_IN, 0, lat);
    chk("zero_latency", 128'(lat), 128'd17);
    chk("zero_data", bus.data_o, ZERO_OUT);
    @(negedge clk);
    chk("zero_back_idle", 128'(bus.ready_o), 128'd1);
    chk("zero_v_drop", 128'(bus.v_o), 128'd0);

    // Ordered bytes, then 20 cycles of backpressure
    bus.ready_i = 1'b0;
    run_block(ORD_IN, 0, lat);
    chk("ord_latency", 128'(lat), 128'd17);
    chk("ord_data", bus.data_o, ORD_OUT);
    held = bus.data_o;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_v", 128'(bus.v_o), 128'd1);
      chk("bp_data", bus.data_o, held);
      chk("bp_ready", 128'(bus.ready_o), 128'd0);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 128'(bus.ready_o), 128'd1);
    chk("bp_release_v", 128'(bus.v_o), 128'd0);

    // Mixed bytes with a stray block pulsed in BUSY cycle 5
    bus.ready_i = 1'b0;
    run_block(MIX_IN, 5, lat);
    chk("mix_latency", 128'(lat), 128'd17);
    chk("mix_data", bus.data_o, MIX_OUT);
    bus.ready_i = 1'b1;
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.v_o || !bus.ready_o) seen++;
      @(negedge clk);
    end
    chk("stray_never_seen", 128'(seen), 128'd0);

    // Continuous v_i/ready_i: DONE never accepts, period is 18 cycles
    bus.v_i    = 1'b1;
    bus.data_i = ORD_IN;
    lat = 0;
    while (!bus.v_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("stream_first_latency", 128'(lat), 128'd17);
    @(negedge clk);
    chk("stream_done_to_idle", 128'(bus.ready_o), 128'd1);
    lat = 1;
    while (!bus.v_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("stream_period", 128'(lat), 128'd18);
    chk("stream_data", bus.data_o, ORD_OUT);
    bus.v_i    = 1'b0;
    bus.data_i = '0;
    @(negedge clk);
    chk("stream_end_idle", 128'(bus.ready_o), 128'd1);

    // Asynchronous reset in BUSY cycle 8
    bus.ready_i = 1'b0;
    bus.v_i     = 1'b1;
    bus.data_i  = ORD_IN;
    @(negedge clk);
    bus.v_i    = 1'b0;
    bus.data_i = '0;
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", 128'(bus.ready_o), 128'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 128'(bus.ready_o), 128'd1);
    chk("mid_rst_v", 128'(bus.v_o), 128'd0);
    chk("mid_rst_data", bus.data_o, 128'd0);
    @(negedge clk);
    chk("rst_held_v", 128'(bus.v_o), 128'd0);
    rst_n = 1'b1;
    run_block(ZERO_IN, 0, lat);
    chk("post_rst_latency", 128'(lat), 128'd17);
    chk("post_rst_data", bus.data_o, ZERO_OUT);
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 128'(bus.ready_o), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
